nibble_serial_add_ctrl: RTL
===========================

Name: nibble_serial_add_ctrl

Overview:
- Sequencer that adds two NIBBLES×4-bit operands by time-multiplexing one external 4-bit ripple adder with carry-in, one nibble per clock, LSB nibble first.
- Owns the operand registers, carry register, result register, nibble counter and the start/busy/done handshake.
- Sits between a requesting master and the shared 4-bit adder instance. The adder stays purely combinational.

Parameters:
- NIBBLES, 4, operand width in nibbles (operand width W = 4*NIBBLES). Legal range is 2..8.

Ports:
- CLK  input  1  system clock, rising-edge active
- RSTN  input  1  asynchronous active-low reset
- START  input  1  request pulse, sampled on CLK rising edge
- A  input  W  operand A, sampled with accepted START
- B  input  W  operand B, sampled with accepted START
- BUSY  output  1  high while a sum is in progress
- DONE  output  1  one-cycle pulse, result valid
- SUM  output  W  result register
- COUT  output  1  final carry out
- ADD_A  output  4  nibble of A driven to the adder
- ADD_B  output  4  nibble of B driven to the adder
- ADD_CIN  output  1  carry into the adder
- ADD_SUM  input  4  adder sum return
- ADD_COUT  input  1  adder carry return

Behaviour:
- Reset (RSTN low, asynchronous):
  - state = IDLE.
  - BUSY = 0, DONE = 0, SUM = 0, COUT = 0.
  - Counter = 0, carry register = 0, operand registers = 0.
  - ADD_A, ADD_B and ADD_CIN therefore read 0.
- States: IDLE, RUN, FIN.
- IDLE:
  - START = 1 → latch A and B into the operand registers, carry register = 0, counter = 0, SUM = 0, COUT = 0, go to RUN.
  - START = 0 → stay in IDLE.
- RUN:
  - BUSY = 1.
  - ADD_A/ADD_B are driven combinationally from operand nibble[counter]; ADD_CIN = carry register.
  - Each edge: SUM nibble[counter] ← ADD_SUM, carry register ← ADD_COUT, counter increments.
  - On the edge where counter == NIBBLES-1: COUT ← ADD_COUT, counter ← 0, go to FIN.
- FIN:
  - DONE = 1 and BUSY = 0 for exactly one cycle.
  - START = 1 → accepted exactly as in IDLE (back-to-back operation), go to RUN.
  - Otherwise go to IDLE.
- Latency: START accepted at edge k → BUSY high after edges k..k+NIBBLES-1 → DONE high in the cycle after edge k+NIBBLES. Total NIBBLES+1 cycles from accept to DONE.
- Result hold: SUM and COUT hold their value from FIN until the next accepted START.
- START while in RUN: ignored. No queueing, and operand registers are unaffected.
- Changes on A/B after the accept edge: no effect on the result.
- Reset mid-operation: the operation is aborted, all outputs return to reset values, and no DONE is issued.
- Arithmetic: unsigned modulo 2^W, with COUT = bit W of A+B.
- DONE and BUSY are never high in the same cycle.

Optional Feature:
- Macro: NIBBLE_SERIAL_SUB_EN.
- When defined:
  - Extra port SUB (input, 1 bit) is sampled with an accepted START.
  - SUB = 1 → the operand B register holds ~B and the carry register initialises to 1, giving SUM = A-B mod 2^W.
  - With SUB = 1, COUT = 1 means no borrow (A ≥ B).
  - SUB = 0 → identical to plain add.
- When undefined: no SUB port; add only, and the initial carry is always 0.

Test Plan:
- NIBBLES = 4, A = 0x1234, B = 0x4321, one START pulse → BUSY high for 4 cycles, DONE pulse on the 5th cycle, SUM = 0x5555, COUT = 0. During the run, ADD_A sequence = 4, 3, 2, 1.
- A = 0xFFFF, B = 0x0001 → carry ripples across all nibbles (ADD_CIN = 0, 1, 1, 1), SUM = 0x0000, COUT = 1.
- Operation running with A = 0x00FF, B = 0x0001; at the 2nd RUN cycle, START with A = 0xAAAA, B = 0x5555 → ignored, SUM = 0x0100, COUT = 0, exactly one DONE.
- START held high continuously with A = 0x0001, B = 0x0001 → accept, DONE, immediate re-accept in the FIN cycle; DONE every 5 cycles, SUM = 0x0002 each time, BUSY low only in FIN cycles.
- RSTN pulled low at the 3rd RUN cycle → BUSY, DONE, SUM and COUT go to 0 immediately; no DONE follows; the next START runs normally.
- NIBBLE_SERIAL_SUB_EN defined: A = 0x0005, B = 0x0007, SUB = 1 → SUM = 0xFFFE, COUT = 0. A = 0x0007, B = 0x0005, SUB = 1 → SUM = 0x0002, COUT = 1.

Source files
------------

// File: rtl/nibble_serial_add_ctrl.sv
// Serial adder sequencer: one shared 4-bit adder, one nibble per clock.
// Optional subtract mode enabled with NIBBLE_SERIAL_SUB_EN.
module nibble_serial_add_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                 CLK,
    input  logic                 RSTN,
    input  logic                 START,
    input  logic [4*NIBBLES-1:0] A,
    input  logic [4*NIBBLES-1:0] B,
`ifdef NIBBLE_SERIAL_SUB_EN
    input  logic                 SUB,
`endif
    output logic                 BUSY,
    output logic                 DONE,
    output logic [4*NIBBLES-1:0] SUM,
    output logic                 COUT,
    output logic [3:0]           ADD_A,
    output logic [3:0]           ADD_B,
    output logic                 ADD_CIN,
    input  logic [3:0]           ADD_SUM,
    input  logic                 ADD_COUT
);

    localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t               state;
    logic [4*NIBBLES-1:0] opa;
    logic [4*NIBBLES-1:0] opb;
    logic [4*NIBBLES-1:0] sum_q;
    logic [CW-1:0]        cnt;
    logic                 carry;
    logic                 cout_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 sub_i;
    logic                 last;

`ifdef NIBBLE_SERIAL_SUB_EN
    assign sub_i = SUB;
`else
    assign sub_i = 1'b0;
`endif

    assign last = (cnt == CW'(NIBBLES - 1));

    always_comb begin
        ADD_A = '0;
        ADD_B = '0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (cnt == CW'(i)) begin
                ADD_A = opa[4*i +: 4];
                ADD_B = opb[4*i +: 4];
            end
        end
    end

    assign ADD_CIN = carry;
    assign BUSY    = busy_q;
    assign DONE    = done_q;
    assign SUM     = sum_q;
    assign COUT    = cout_q;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state  <= IDLE;
            opa    <= '0;
            opb    <= '0;
            sum_q  <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
            cout_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE, FIN: begin
                    done_q <= 1'b0;
                    if (START) begin
                        opa    <= A;
                        // Subtract is A + ~B + 1 through the same adder
                        opb    <= sub_i ? ~B : B;
                        carry  <= sub_i;
                        cnt    <= '0;
                        sum_q  <= '0;
                        cout_q <= 1'b0;
                        busy_q <= 1'b1;
                        state  <= RUN;
                    end else begin
                        state  <= IDLE;
                    end
                end
                RUN: begin
                    for (int i = 0; i < NIBBLES; i++) begin
                        if (cnt == CW'(i)) begin
                            sum_q[4*i +: 4] <= ADD_SUM;
                        end
                    end
                    carry <= ADD_COUT;
                    if (last) begin
                        cout_q <= ADD_COUT;
                        cnt    <= '0;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= FIN;
                    end else begin
                        cnt    <= cnt + 1'b1;
                    end
                end
                default: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule
